receptor_medida_ascii: RTL and testbench

- Receive side of the turret's serial measurement link: accepts the 8-character ASCII frame "CCC,DDD#" (angle hundreds/tens/units, comma, distance hundreds/tens/units, hash) on one serial line.
- Decodes each frame into BCD angle and distance.
- Sits in the monitoring/host-side board, or in the loopback test harness, facing the turret's ASCII transmitter.
- Contains its own bit-level UART receiver plus a frame parser; only complete, fully valid frames update the outputs.

---
 rtl/receptor_medida_ascii.sv | 197 +++++++++++++++++++
 tb/tb_receptor_medida_ascii.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/receptor_medida_ascii.sv
// Purpose: UART receiver and parser for "CCC,DDD#" ASCII frames, decoded to BCD angle and distance.
// Latency: angulo/distancia/pronto update 2 cycles after the clock edge that samples STOP2 of the '#'.
// Backpressure: none; the serial line cannot be stalled, and outputs hold until the next valid frame.
module receptor_medida_ascii #(
  parameter int CICLOS_BIT     = 434,
  parameter int PARIDADE_IMPAR = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        pronto,
  output logic        erro_quadro,
  output logic [3:0]  db_estado
);

  localparam int MEIO = CICLOS_BIT / 2;
  localparam int CW   = $clog2(CICLOS_BIT);

  typedef enum logic [3:0] {
    ESPERA   = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    STOP1    = 4'd4,
    STOP2    = 4'd5,
    FIM      = 4'd6
  } estado_t;

  estado_t estado, prox;

  logic          sinc1, linha;
  logic [CW-1:0] cnt;
  logic [2:0]    nbits;
  logic [6:0]    dado;
  logic          bit_par, bit_stop1, bit_stop2;
  logic          quebra;
  logic          fim_meio, fim_bit;
  logic          paridade_ok;
  logic          char_ok, char_bad;
  logic          ok_q, bad_q;
  logic [6:0]    dat_q;

  logic [2:0]    idx;
  logic          resync;
  logic          casa;
  logic [11:0]   sh_a, sh_d;

  assign fim_meio = (cnt == CW'(MEIO - 1));
  assign fim_bit  = (cnt == CW'(CICLOS_BIT - 1));
  assign paridade_ok = ((^{dado, bit_par}) == (PARIDADE_IMPAR != 0));

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1 <= 1'b1;
      linha <= 1'b1;
    end else begin
      sinc1 <= entrada_serial;
      linha <= sinc1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= ESPERA;
    else        estado <= prox;
  end

  // Receiver next-state: a break (stop sampled low) blocks new starts until the line returns high.
  always_comb begin
    prox = estado;
    unique case (estado)
      ESPERA:   if (!linha && !quebra) prox = INICIO;
      INICIO:   if (fim_meio) prox = linha ? ESPERA : DADOS;
      DADOS:    if (fim_bit && nbits == 3'd6) prox = PARIDADE;
      PARIDADE: if (fim_bit) prox = STOP1;
      STOP1:    if (fim_bit) prox = STOP2;
      STOP2:    if (fim_bit) prox = FIM;
      FIM:      prox = ESPERA;
      default:  prox = ESPERA;
    endcase
  end

  // Receiver outputs: character verdict only during the single FIM cycle.
  always_comb begin
    char_ok   = 1'b0;
    char_bad  = 1'b0;
    db_estado = estado;
    if (estado == FIM) begin
      char_ok  = bit_stop1 && bit_stop2 && paridade_ok;
      char_bad = !(bit_stop1 && bit_stop2 && paridade_ok);
    end
  end

  // Bit timing counter, data shifter and framing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      nbits     <= '0;
      dado      <= '0;
      bit_par   <= 1'b0;
      bit_stop1 <= 1'b0;
      bit_stop2 <= 1'b0;
      quebra    <= 1'b0;
    end else begin
      if (estado != prox || (estado == DADOS && fim_bit) ||
          estado == ESPERA || estado == FIM)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (estado != DADOS)
        nbits <= '0;
      else if (fim_bit)
        nbits <= nbits + 3'd1;

      if (estado == DADOS && fim_bit)    dado      <= {linha, dado[6:1]};
      if (estado == PARIDADE && fim_bit) bit_par   <= linha;
      if (estado == STOP1 && fim_bit)    bit_stop1 <= linha;
      if (estado == STOP2 && fim_bit)    bit_stop2 <= linha;

      if (estado == FIM && !bit_stop2)   quebra <= 1'b1;
      else if (estado == ESPERA && linha) quebra <= 1'b0;
    end
  end

  // Register the character verdict and data, giving the parser a clean one-cycle event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ok_q  <= 1'b0;
      bad_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ok_q  <= char_ok;
      bad_q <= char_bad;
      if (estado == FIM) dat_q <= dado;
    end
  end

  // Expected character for the current frame position.
  always_comb begin
    casa = 1'b0;
    case (idx)
      3'd3:    casa = (dat_q == 7'h2C);
      3'd7:    casa = (dat_q == 7'h23);
      default: casa = (dat_q >= 7'h30) && (dat_q <= 7'h39);
    endcase
  end

  // Frame parser: digits go to shadow registers; outputs only change on a complete frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      resync      <= 1'b0;
      sh_a        <= '0;
      sh_d        <= '0;
      angulo      <= '0;
      distancia   <= '0;
      pronto      <= 1'b0;
      erro_quadro <= 1'b0;
    end else begin
      pronto      <= 1'b0;
      erro_quadro <= 1'b0;
      if (ok_q || bad_q) begin
        if (resync) begin
          if (ok_q && dat_q == 7'h23) resync <= 1'b0;
        end else if (ok_q && casa) begin
          case (idx)
            3'd0: sh_a[11:8] <= dat_q[3:0];
            3'd1: sh_a[7:4]  <= dat_q[3:0];
            3'd2: sh_a[3:0]  <= dat_q[3:0];
            3'd4: sh_d[11:8] <= dat_q[3:0];
            3'd5: sh_d[7:4]  <= dat_q[3:0];
            3'd6: sh_d[3:0]  <= dat_q[3:0];
            default: ;
          endcase
          if (idx == 3'd7) begin
            angulo    <= sh_a;
            distancia <= sh_d;
            pronto    <= 1'b1;
            idx       <= '0;
          end else begin
            idx <= idx + 3'd1;
          end
        end else begin
          // A rejected '#' is itself the resync point, so no hunt is needed.
          erro_quadro <= 1'b1;
          idx         <= '0;
          resync      <= !(ok_q && dat_q == 7'h23);
        end
      end
    end
  end

endmodule

// File: tb/tb_receptor_medida_ascii.sv
module tb_receptor_medida_ascii;

  localparam int CB = 40;

  logic        clock;
  logic        reset;
  logic        entrada_serial;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        pronto;
  logic        erro_quadro;
  logic [3:0]  db_estado;

  int n_total = 0;
  int n_pass  = 0;
  int n_pronto = 0;
  int n_erro = 0;
  int cyc = 0;
  int cyc_fim = 0;
  int lat = 0;
  int ambos = 0;
  logic [3:0] est_ant = 4'd0;
  int p0, e0;

  receptor_medida_ascii #(.CICLOS_BIT(CB), .PARIDADE_IMPAR(1)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .angulo         (angulo),
    .distancia      (distancia),
    .pronto         (pronto),
    .erro_quadro    (erro_quadro),
    .db_estado      (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters and pronto latency measured from entry into FIM.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (db_estado == 4'd6 && est_ant != 4'd6) cyc_fim = cyc;
    est_ant = db_estado;
    if (pronto) begin
      n_pronto = n_pronto + 1;
      lat = cyc - cyc_fim;
    end
    if (erro_quadro) n_erro = n_erro + 1;
    if (pronto && erro_quadro) ambos = 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_char(input logic [6:0] c, input logic flip);
    logic par;
    par = ~(^c) ^ flip;
    entrada_serial = 1'b0;
    tick(CB);
    for (int i = 0; i < 7; i++) begin
      entrada_serial = c[i];
      tick(CB);
    end
    entrada_serial = par;
    tick(CB);
    entrada_serial = 1'b1;
    tick(2 * CB);
  endtask

  task automatic send_frame(input string s, input int bad);
    byte b;
    for (int i = 0; i < 8; i++) begin
      b = s[i];
      send_char(b[6:0], i == bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    entrada_serial = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("rst_angulo", angulo, 12'h000);
    check("rst_distancia", distancia, 12'h000);
    check("rst_pronto", pronto, 1'b0);
    check("rst_erro", erro_quadro, 1'b0);
    check("rst_estado", db_estado, 4'd0);
    reset = 1'b1;
    tick(5);

    // Clean frame
    send_frame("090,045#", -1);
    check("f1_npronto", n_pronto, 1);
    check("f1_angulo", angulo, 12'h090);
    check("f1_distancia", distancia, 12'h045);
    check("f1_nerro", n_erro, 0);
    check("f1_latencia", lat, 2);

    // Back-to-back frame, no idle gap
    send_frame("120,007#", -1);
    check("f2_npronto", n_pronto, 2);
    check("f2_angulo", angulo, 12'h120);
    check("f2_distancia", distancia, 12'h007);
    check("f2_latencia", lat, 2);

    // Parity error on the fifth character
    e0 = n_erro;
    send_frame("030,100#", 4);
    check("par_nerro", n_erro - e0, 1);
    check("par_npronto", n_pronto, 2);
    check("par_angulo", angulo, 12'h120);
    check("par_distancia", distancia, 12'h007);
    send_frame("045,200#", -1);
    send_frame("045,200#", -1);
    check("par_rec_angulo", angulo, 12'h045);
    check("par_rec_distancia", distancia, 12'h200);
    check("par_rec_nerro", n_erro - e0, 1);

    // Wrong separator
    p0 = n_pronto;
    e0 = n_erro;
    send_frame("0901045#", -1);
    check("sep_nerro", n_erro - e0, 1);
    check("sep_npronto", n_pronto - p0, 0);
    check("sep_angulo", angulo, 12'h045);
    check("sep_distancia", distancia, 12'h200);
    send_frame("010,020#", -1);
    check("sep_rec_npronto", n_pronto - p0, 1);
    check("sep_rec_angulo", angulo, 12'h010);
    check("sep_rec_distancia", distancia, 12'h020);
    check("sep_rec_nerro", n_erro - e0, 1);

    // Short low glitch on idle line
    p0 = n_pronto;
    e0 = n_erro;
    entrada_serial = 1'b0;
    tick(10);
    entrada_serial = 1'b1;
    tick(3 * CB);
    check("glitch_estado", db_estado, 4'd0);
    check("glitch_nerro", n_erro - e0, 0);
    check("glitch_npronto", n_pronto - p0, 0);

    // Break: line held low for well over one character
    e0 = n_erro;
    entrada_serial = 1'b0;
    tick(14 * CB);
    check("break_estado", db_estado, 4'd0);
    check("break_nerro", n_erro - e0, 1);
    entrada_serial = 1'b1;
    tick(2 * CB);
    send_char(7'h23, 1'b0);
    tick(CB);
    check("break_hash_nerro", n_erro - e0, 1);
    check("break_angulo", angulo, 12'h010);

    // Reset in the middle of the sixth character
    send_char(7'h31, 1'b0);
    send_char(7'h31, 1'b0);
    send_char(7'h31, 1'b0);
    send_char(7'h2C, 1'b0);
    send_char(7'h32, 1'b0);
    entrada_serial = 1'b0;
    tick(CB + CB / 2);
    reset = 1'b0;
    #1;
    check("mid_rst_angulo", angulo, 12'h000);
    check("mid_rst_distancia", distancia, 12'h000);
    check("mid_rst_estado", db_estado, 4'd0);
    check("mid_rst_pronto", pronto, 1'b0);
    entrada_serial = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2 * CB);
    e0 = n_erro;
    send_char(7'h32, 1'b0);
    send_char(7'h23, 1'b0);
    check("mid_rst_tail_nerro", n_erro - e0, 1);
    p0 = n_pronto;
    send_frame("075,180#", -1);
    check("final_npronto", n_pronto - p0, 1);
    check("final_angulo", angulo, 12'h075);
    check("final_distancia", distancia, 12'h180);
    check("final_latencia", lat, 2);
    check("pronto_erro_juntos", ambos, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
